brlshr32_pipe: RTL and testbench

- Pipelined right barrel shifter: the right-direction counterpart of the team's left rotate/shift barrel units.
- Performs logical shift right, arithmetic shift right and (optionally) rotate right of a WIDTH-bit operand by a 0..WIDTH-1 count.
- Uses one log2 stage per count bit, with valid/ready handshakes on both sides.
- Sits between the ALU operand latch and the writeback mux; also supplies carry and zero flags.

---
 rtl/brlshr_pkg.sv | 30 +++
 rtl/brlshr_stage.sv | 37 +++
 rtl/brlshr32_pipe.sv | 58 +++++
 tb/tb_brlshr32_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/brlshr_pkg.sv
// brlshr_pkg: op encoding, fill modes and stage payload shared by brlshr32_pipe (rotate gated by BRLSHR_ROTATE_EN)
package brlshr_pkg;
   localparam int PKG_WIDTH = 32;
   localparam int PKG_TAGW  = 4;
   localparam int PKG_CNTW  = $clog2(PKG_WIDTH);
   localparam logic [1:0] OP_SHR = 2'b00;
   localparam logic [1:0] OP_SAR = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
   typedef enum logic [1:0] {FILL_ZERO, FILL_SIGN, FILL_WRAP, FILL_NONE} fill_t;
   typedef struct packed {
      logic                valid;
      logic [1:0]          op;
      logic [PKG_CNTW-1:0] cnt;
      logic [PKG_WIDTH-1:0] data;
      logic                cf;
      logic [PKG_TAGW-1:0] tag;
   } stage_t;
   function automatic fill_t fill_of(input logic [1:0] op);
`ifdef BRLSHR_ROTATE_EN
      return (op == OP_SAR) ? FILL_SIGN : (op == OP_ROR) ? FILL_WRAP : (op == OP_RSV) ? FILL_NONE : FILL_ZERO;
`else
      return (op == OP_SAR) ? FILL_SIGN : (op == OP_RSV) ? FILL_NONE : FILL_ZERO;
`endif
   endfunction
   // Last bit shifted out is taken from the unshifted operand; the reserved op never shifts
   function automatic logic carry_of(input logic [1:0] op, input logic [PKG_CNTW-1:0] cnt, input logic [PKG_WIDTH-1:0] arg);
      return (op != OP_RSV && cnt != '0) ? arg[cnt - 1'b1] : 1'b0;
   endfunction
endpackage

// File: rtl/brlshr_stage.sv
// brlshr_stage: one registered conditional right shift by SHAMT; wrap fill only built with BRLSHR_ROTATE_EN
module brlshr_stage
   import brlshr_pkg::*;
#(
   parameter int SHAMT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adv,
   input  fill_t                mode,
   input  logic                 cbit,
   input  stage_t               d,
   output logic [PKG_WIDTH-1:0] nxt,
   output stage_t               q
);
   localparam int W = PKG_WIDTH;
   logic [W-1:0] shr, sar;
   assign shr = d.data >> SHAMT;
   assign sar = {{SHAMT{d.data[W-1]}}, d.data[W-1:SHAMT]};
`ifdef BRLSHR_ROTATE_EN
   logic [W-1:0] ror;
   assign ror = {d.data[SHAMT-1:0], d.data[W-1:SHAMT]};
   // Pick the shifted word for this fill mode, or pass through when this count bit is clear
   always_comb nxt = (!cbit || mode == FILL_NONE) ? d.data : (mode == FILL_SIGN) ? sar : (mode == FILL_WRAP) ? ror : shr;
`else
   // Pick the shifted word for this fill mode, or pass through when this count bit is clear
   always_comb nxt = (!cbit || mode == FILL_NONE) ? d.data : (mode == FILL_SIGN) ? sar : shr;
`endif
   // Move with the global stall; payload only follows real operations so idle outputs keep their last values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else if (adv) begin
         q.valid <= d.valid;
         if (d.valid) q <= '{valid: 1'b1, op: d.op, cnt: d.cnt, data: nxt, cf: d.cf, tag: d.tag};
      end
   end
endmodule

// File: rtl/brlshr32_pipe.sv
// brlshr32_pipe: pipelined right shifter (SHR/SAR, ROR when BRLSHR_ROTATE_EN is defined) with carry/zero flags and tag
module brlshr32_pipe
   import brlshr_pkg::*;
#(
   parameter int WIDTH = PKG_WIDTH,
   parameter int CNTW  = $clog2(WIDTH),
   parameter int TAGW  = PKG_TAGW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [1:0]       in_op,
   input  logic [CNTW-1:0]  in_cnt,
   input  logic [WIDTH-1:0] in_arg,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cf,
   output logic             out_zf,
   output logic [TAGW-1:0]  out_tag
);
   stage_t           ds  [CNTW];
   stage_t           qs  [CNTW];
   logic [WIDTH-1:0] nxt [CNTW];
   logic             adv, zf, unused;
   assign adv    = ~qs[CNTW-1].valid | out_rdy;
   assign in_rdy = adv;
   for (genvar k = 0; k < CNTW; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign ds[k] = '{valid: in_vld, op: in_op, cnt: in_cnt, data: in_arg, cf: carry_of(in_op, in_cnt, in_arg), tag: in_tag};
      end else begin : g_body
         assign ds[k] = qs[k-1];
      end
      brlshr_stage #(.SHAMT(1 << (CNTW - 1 - k))) u_stage (
         .clk  (clk),
         .rst  (rst),
         .adv  (adv),
         .mode (fill_of(ds[k].op)),
         .cbit (ds[k].cnt[CNTW-1-k]),
         .d    (ds[k]),
         .nxt  (nxt[k]),
         .q    (qs[k])
      );
   end
   // Zero flag is registered alongside the final result so it clears on reset and holds while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) zf <= 1'b0;
      else if (adv && ds[CNTW-1].valid) zf <= (nxt[CNTW-1] == '0);
   end
   assign out_vld = qs[CNTW-1].valid;
   assign out_res = qs[CNTW-1].data;
   assign out_cf  = qs[CNTW-1].cf;
   assign out_zf  = zf;
   assign out_tag = qs[CNTW-1].tag;
   assign unused  = ^{qs[CNTW-1].op, qs[CNTW-1].cnt};
endmodule

// File: tb/tb_brlshr32_pipe.sv
// tb_brlshr32_pipe: scoreboard bench for brlshr32_pipe; honours BRLSHR_ROTATE_EN in its reference model
`timescale 1ns/1ps
module tb_brlshr32_pipe;
   localparam int W  = 32;
   localparam int CW = 5;
   localparam int TW = 4;
   typedef struct packed {
      logic [W-1:0]  res;
      logic          cf;
      logic          zf;
      logic [TW-1:0] tag;
   } exp_t;
   logic          clk = 1'b0, rst = 1'b1, in_vld = 1'b0, out_rdy = 1'b1;
   logic          in_rdy, out_vld, out_cf, out_zf;
   logic [1:0]    in_op = '0;
   logic [CW-1:0] in_cnt = '0;
   logic [W-1:0]  in_arg = '0, out_res;
   logic [TW-1:0] in_tag = '0, out_tag;
   int            checks = 0, errors = 0;
   bit            rnd_done = 1'b0;
   exp_t          sb[$];
   always #5 clk = ~clk;
   brlshr32_pipe dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_cnt(in_cnt),
      .in_arg(in_arg), .in_tag(in_tag), .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
      .out_cf(out_cf), .out_zf(out_zf), .out_tag(out_tag)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic exp_t mk(input logic [W-1:0] res, input logic cf, input logic [TW-1:0] tag);
      return '{res: res, cf: cf, zf: (res == 0), tag: tag};
   endfunction
   // Reference: plain shift/rotate arithmetic on the whole operand
   function automatic exp_t model(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] a, input logic [TW-1:0] tag);
      logic [2*W-1:0] t;
      logic [W-1:0]   r;
      logic           cf;
      t = {a, a} >> cnt;
      case (op)
         2'b00: r = a >> cnt;
         2'b01: r = $signed(a) >>> cnt;
`ifdef BRLSHR_ROTATE_EN
         2'b10: r = t[W-1:0];
`else
         2'b10: r = a >> cnt;
`endif
         default: r = a;
      endcase
      cf = (op != 2'b11 && cnt != 0) ? a[cnt - 1] : 1'b0;
      return mk(r, cf, tag);
   endfunction
   task automatic xfer(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] arg, input logic [TW-1:0] tag, input exp_t e);
      int w = 0;
      @(negedge clk);
      in_vld = 1'b1; in_op = op; in_cnt = cnt; in_arg = arg; in_tag = tag;
      #1;
      while (!in_rdy) begin
         w++;
         if (w > 100) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: in_rdy stuck at %0b required 1", in_rdy);
            in_vld = 1'b0;
            return;
         end
         @(negedge clk); #1;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      in_vld = 1'b0;
   endtask
   task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] arg, input logic [TW-1:0] tag);
      xfer(op, cnt, arg, tag, model(op, cnt, arg, tag));
   endtask
   task automatic lat(input string name, input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] arg, input logic [TW-1:0] tag, input exp_t e);
      int cyc = 0;
      xfer(op, cnt, arg, tag, e);
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_vld && cyc < 20);
      check(name, cyc, CW);
   endtask
   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk); #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask
   // Monitor: every accepted output is matched against the oldest expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (!rst && out_vld && out_rdy) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_out: tag %0h res %0h with empty scoreboard", out_tag, out_res);
            end else begin
               e = sb.pop_front();
               check("out_res", out_res, e.res);
               check("out_cf", out_cf, e.cf);
               check("out_zf", out_zf, e.zf);
               check("out_tag", out_tag, e.tag);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      #12;
      check("rst_vld", out_vld, 0);
      check("rst_rdy", in_rdy, 1);
      check("rst_res", out_res, 0);
      check("rst_flags", {out_cf, out_zf, out_tag}, 0);
      #10 rst = 1'b0;
      lat("latency_first", 2'b00, 5'd1, 32'h8000_0001, 4'd1, mk(32'h4000_0000, 1'b1, 4'd1));
      xfer(2'b01, 5'd31, 32'h8000_0000, 4'd2, mk(32'hFFFF_FFFF, 1'b0, 4'd2));
      xfer(2'b00, 5'd31, 32'h8000_0000, 4'd3, mk(32'h0000_0001, 1'b0, 4'd3));
`ifdef BRLSHR_ROTATE_EN
      xfer(2'b10, 5'd4, 32'h0000_0001, 4'd4, mk(32'h1000_0000, 1'b0, 4'd4));
      xfer(2'b10, 5'd31, 32'h8000_0001, 4'd5, mk(32'h0000_0003, 1'b0, 4'd5));
`else
      xfer(2'b10, 5'd4, 32'h0000_0001, 4'd4, mk(32'h0000_0000, 1'b0, 4'd4));
      xfer(2'b10, 5'd31, 32'h8000_0001, 4'd5, mk(32'h0000_0001, 1'b0, 4'd5));
`endif
      xfer(2'b00, 5'd0, 32'hDEAD_BEEF, 4'd6, mk(32'hDEAD_BEEF, 1'b0, 4'd6));
      xfer(2'b11, 5'd7, 32'hDEAD_BEEF, 4'd7, mk(32'hDEAD_BEEF, 1'b0, 4'd7));
      xfer(2'b01, 5'd31, 32'h7FFF_FFFF, 4'd8, mk(32'h0000_0000, 1'b1, 4'd8));
      xfer(2'b01, 5'd0, 32'h8000_0000, 4'd9, mk(32'h8000_0000, 1'b0, 4'd9));
      xfer(2'b01, 5'd5, 32'hF000_0010, 4'd10, mk(32'hFF80_0000, 1'b1, 4'd10));
      drain();
      // Back-pressure: eight ops against a stalled consumer, then release
      fork
         for (int i = 0; i < 8; i++) begin
            logic [3:0] t;
            t = 4'(i);
            send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, t);
         end
         begin
            logic [W-1:0]  held_res;
            logic [TW-1:0] held_tag;
            bit            seen = 1'b0;
            @(negedge clk);
            out_rdy = 1'b0;
            repeat (10) begin
               @(negedge clk); #3;
               if (out_vld) begin
                  check("bp_in_rdy", in_rdy, 0);
                  if (!seen) begin
                     held_res = out_res; held_tag = out_tag; seen = 1'b1;
                     check("bp_head_tag", out_tag, 0);
                  end else begin
                     check("bp_hold_res", out_res, held_res);
                     check("bp_hold_tag", out_tag, held_tag);
                  end
               end
            end
            check("bp_vld", out_vld, 1);
            @(negedge clk);
            out_rdy = 1'b1;
         end
      join
      drain();
      // Random ops with random consumer readiness
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [3:0] t;
               t = 4'(i);
               send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, t);
            end
            rnd_done = 1'b1;
         end
         while (!rnd_done) begin
            @(negedge clk);
            out_rdy = ($urandom_range(0, 3) != 0);
         end
      join
      out_rdy = 1'b1;
      drain();
      // Asynchronous reset with three ops in flight
      for (int i = 0; i < 3; i++) send(2'b00, 5'd1, 32'hFFFF_FFFF, 4'hA);
      #2 rst = 1'b1;
      #1;
      check("arst_vld", out_vld, 0);
      check("arst_res", out_res, 0);
      check("arst_flags", {out_cf, out_zf, out_tag}, 0);
      check("arst_rdy", in_rdy, 1);
      sb.delete();
      #10 rst = 1'b0;
      repeat (8) begin
         @(negedge clk); #3;
         check("post_rst_idle", out_vld, 0);
      end
      lat("latency_after_rst", 2'b01, 5'd3, 32'h8000_0008, 4'd3, mk(32'hF000_0001, 1'b0, 4'd3));
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
